operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/adder_pkg.sv | 15 +
 rtl/operand_loader_beat_counter.sv | 26 ++
 rtl/operand_loader.sv | 125 ++++++++++++
 tb/tb_operand_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the operand loader and the binary_adder side:
// default operand/bus widths, beat count and the loader FSM state encoding.
package adder_pkg;

  localparam int W_OP  = 100;
  localparam int W_IN  = 20;
  localparam int BEATS = W_OP / W_IN;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/operand_loader_beat_counter.sv
// beat_counter: mod-N beat index. clr has priority over inc; wrap flags the
// increment that rolls the index from N-1 back to 0.
module beat_counter #(
  parameter int N  = 5,
  parameter int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  assign wrap = inc && (count == CW'(N - 1));

  // Beat index register: reset/clear to 0, otherwise step on inc.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/operand_loader.sv
// operand_loader: assembles two W_OP-bit operands (a then b, LS word first)
// from a W_IN-bit valid/ready stream and presents them with a carry-in to
// binary_adder through a valid/ready handshake.
// Optional feature: define OPERAND_LOADER_SUB_EN to add in_sub, which turns
// the pair into a subtraction (op_b inverted, op_cin forced to 1).
//
// state  | meaning
// LOAD_A | accepting beats of operand a (first beat also samples cin/sub)
// LOAD_B | accepting beats of operand b
// HOLD   | pair complete, op_valid high, waiting for op_ready
module operand_loader #(
  parameter int W_OP = adder_pkg::W_OP,
  parameter int W_IN = adder_pkg::W_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W_IN-1:0] in_data,
  input  logic            in_cin,
`ifdef OPERAND_LOADER_SUB_EN
  input  logic            in_sub,
`endif
  input  logic            in_abort,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [W_OP-1:0] op_a,
  output logic [W_OP-1:0] op_b,
  output logic            op_cin
);

  localparam int BEATS = W_OP / W_IN;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (W_OP % W_IN != 0) begin : g_width_check
    $error("operand_loader: W_OP must be an integer multiple of W_IN");
  end

  adder_pkg::state_t state_q, state_d;

  logic [CW-1:0]   count;
  logic            wrap;
  logic            accept;
  logic            cnt_clr;
  logic [W_OP-1:0] a_q, b_q;
  logic            cin_q;
  logic            sub_q;

  assign in_ready = (state_q != adder_pkg::HOLD);
  assign op_valid = (state_q == adder_pkg::HOLD);
  // Abort drops any beat presented in the same cycle.
  assign accept   = in_valid && in_ready && !in_abort;
  assign cnt_clr  = in_ready && in_abort;

  beat_counter #(.N(BEATS), .CW(CW)) u_beat_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .clr   (cnt_clr),
    .count (count),
    .wrap  (wrap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= adder_pkg::LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: advance on the last beat of an operand, release on op_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      adder_pkg::LOAD_A: begin
        if (in_abort)           state_d = adder_pkg::LOAD_A;
        else if (accept && wrap) state_d = adder_pkg::LOAD_B;
      end
      adder_pkg::LOAD_B: begin
        if (in_abort)           state_d = adder_pkg::LOAD_A;
        else if (accept && wrap) state_d = adder_pkg::HOLD;
      end
      adder_pkg::HOLD: begin
        if (op_ready) state_d = adder_pkg::LOAD_A;
      end
      default: state_d = adder_pkg::LOAD_A;
    endcase
  end

  // Operand capture: each accepted beat lands in its word slot; cin/sub ride on a's first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      sub_q <= 1'b0;
    end else if (accept) begin
      if (state_q == adder_pkg::LOAD_A) begin
        a_q[int'(count)*W_IN +: W_IN] <= in_data;
        if (count == '0) begin
          cin_q <= in_cin;
`ifdef OPERAND_LOADER_SUB_EN
          sub_q <= in_sub;
`else
          sub_q <= 1'b0;
`endif
        end
      end else begin
        b_q[int'(count)*W_IN +: W_IN] <= in_data;
      end
    end
  end

  assign op_a = a_q;
`ifdef OPERAND_LOADER_SUB_EN
  assign op_b   = sub_q ? ~b_q : b_q;
  assign op_cin = sub_q | cin_q;
`else
  assign op_b   = b_q;
  assign op_cin = cin_q;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with an expected-pair scoreboard.
`timescale 1ns/1ps
module tb_operand_loader;

  localparam int W_OP  = 100;
  localparam int W_IN  = 20;
  localparam int BEATS = W_OP / W_IN;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W_IN-1:0] in_data;
  logic            in_cin;
  logic            in_abort;
  logic            op_valid;
  logic            op_ready;
  logic [W_OP-1:0] op_a;
  logic [W_OP-1:0] op_b;
  logic            op_cin;
`ifdef OPERAND_LOADER_SUB_EN
  logic            in_sub;
`endif

  typedef struct packed {
    logic [W_OP-1:0] a;
    logic [W_OP-1:0] b;
    logic            cin;
    logic [W_OP-1:0] sum;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_loader #(.W_OP(W_OP), .W_IN(W_IN)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_cin   (in_cin),
`ifdef OPERAND_LOADER_SUB_EN
    .in_sub   (in_sub),
`endif
    .in_abort (in_abort),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_cin   (op_cin)
  );

  task automatic check(input string tag, input logic [W_OP-1:0] obs, input logic [W_OP-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [W_IN-1:0] data, input logic cin, input logic abort);
    in_valid = 1'b1;
    in_data  = data;
    in_cin   = cin;
    in_abort = abort;
    @(negedge clk);
    in_valid = 1'b0;
    in_abort = 1'b0;
  endtask

  // Drives a full pair (with optional random idle gaps) and queues the expected result.
  task automatic load_pair(input logic [W_OP-1:0] a, input logic [W_OP-1:0] b,
                           input logic cin, input logic sub, input int max_gap);
    logic [2*W_OP-1:0] words;
    exp_t e;
    int gap;
    words = {b, a};
    for (int i = 0; i < 2*BEATS; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      in_valid = 1'b0;
      repeat (gap) begin
        in_data = W_IN'($urandom);
        in_cin  = ~cin;
        @(negedge clk);
      end
      check("in_ready_load", W_OP'(in_ready), W_OP'(1));
      check("op_valid_load", W_OP'(op_valid), W_OP'(0));
      in_valid = 1'b1;
      in_data  = words[i*W_IN +: W_IN];
      in_cin   = (i == 0) ? cin : ~cin;
`ifdef OPERAND_LOADER_SUB_EN
      in_sub   = (i == 0) ? sub : ~sub;
`endif
      @(negedge clk);
    end
    in_valid = 1'b0;
    e.a   = a;
    e.b   = sub ? ~b : b;
    e.cin = sub ? 1'b1 : cin;
    e.sum = e.a + e.b + W_OP'(e.cin);
    sb.push_back(e);
  endtask

  // Waits (bounded) for op_valid, compares against the scoreboard, optionally
  // stalls in HOLD with abort/valid noise, then releases with one op_ready cycle.
  task automatic expect_pair(input int hold_cycles);
    int n;
    exp_t e;
    logic [W_OP-1:0] s;
    n = 0;
    while (op_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("op_valid_latency", W_OP'(n), W_OP'(0));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    s = op_a + op_b + W_OP'(op_cin);
    check("op_a", op_a, e.a);
    check("op_b", op_b, e.b);
    check("op_cin", W_OP'(op_cin), W_OP'(e.cin));
    check("adder_sum", s, e.sum);
    for (int k = 0; k < hold_cycles; k++) begin
      op_ready = 1'b0;
      in_valid = 1'b1;
      in_abort = 1'b1;
      in_data  = W_IN'($urandom);
      @(negedge clk);
      check("hold_in_ready", W_OP'(in_ready), W_OP'(0));
      check("hold_op_valid", W_OP'(op_valid), W_OP'(1));
      check("hold_op_a", op_a, e.a);
      check("hold_op_b", op_b, e.b);
      check("hold_op_cin", W_OP'(op_cin), W_OP'(e.cin));
    end
    in_valid = 1'b0;
    in_abort = 1'b0;
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check("release_in_ready", W_OP'(in_ready), W_OP'(1));
    check("release_op_valid", W_OP'(op_valid), W_OP'(0));
  endtask

  task automatic pulse_reset_and_check(input string tag);
    rst = 1'b1;
    in_abort = 1'b1;
    op_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_abort = 1'b0;
    op_ready = 1'b0;
    check({tag, "_op_valid"}, W_OP'(op_valid), W_OP'(0));
    check({tag, "_in_ready"}, W_OP'(in_ready), W_OP'(1));
    check({tag, "_op_a"}, op_a, '0);
    check({tag, "_op_b"}, op_b, '0);
    check({tag, "_op_cin"}, W_OP'(op_cin), W_OP'(0));
    repeat (3) begin
      @(negedge clk);
      check({tag, "_no_valid"}, W_OP'(op_valid), W_OP'(0));
    end
  endtask

  initial begin
    logic [W_OP-1:0] ra, rb;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_cin   = 1'b0;
    in_abort = 1'b0;
    op_ready = 1'b0;
`ifdef OPERAND_LOADER_SUB_EN
    in_sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_op_valid", W_OP'(op_valid), W_OP'(0));
    check("rst_in_ready", W_OP'(in_ready), W_OP'(1));
    check("rst_op_a", op_a, '0);
    check("rst_op_b", op_b, '0);
    check("rst_op_cin", W_OP'(op_cin), W_OP'(0));

    // a=1, b=2, cin=1, back-to-back beats: sum 4.
    load_pair(W_OP'(1), W_OP'(2), 1'b1, 1'b0, 0);
    expect_pair(0);

    // a=all ones, b=0, cin=1 with random gaps: sum wraps to 0.
    load_pair({W_OP{1'b1}}, '0, 1'b1, 1'b0, 2);
    expect_pair(0);

    // Random pair, then a 20-cycle stall in HOLD with abort/valid noise.
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    load_pair(ra, rb, 1'b0, 1'b0, 1);
    expect_pair(20);

    // Abort on a's third beat (beat dropped), then reload a=5, b=3.
    beat(20'hDEAD1, 1'b1, 1'b0);
    beat(20'hDEAD2, 1'b1, 1'b0);
    beat(20'hDEAD3, 1'b1, 1'b1);
    check("abort_in_ready", W_OP'(in_ready), W_OP'(1));
    load_pair(W_OP'(5), W_OP'(3), 1'b0, 1'b0, 0);
    expect_pair(0);

    // Abort during LOAD_B must restart at operand a.
    for (int i = 0; i < BEATS + 1; i++) beat(20'hBEEF0 + W_IN'(i), 1'b1, 1'b0);
    beat(20'hBAD00, 1'b1, 1'b1);
    load_pair(W_OP'(7), W_OP'(9), 1'b1, 1'b0, 1);
    expect_pair(0);

    // Reset in LOAD_B.
    for (int i = 0; i < BEATS + 2; i++) beat(20'hCAFE0 + W_IN'(i), 1'b1, 1'b0);
    pulse_reset_and_check("rst_load_b");

    // Reset in HOLD: the committed pair must be discarded.
    load_pair(W_OP'(123), W_OP'(456), 1'b1, 1'b0, 0);
    void'(sb.pop_back());
    check("hold_before_rst", W_OP'(op_valid), W_OP'(1));
    pulse_reset_and_check("rst_hold");

    // Loading still works after reset.
    load_pair(W_OP'(1000), W_OP'(2000), 1'b0, 1'b0, 0);
    expect_pair(0);

`ifdef OPERAND_LOADER_SUB_EN
    // a=10, b=3 subtract: sum 7.
    load_pair(W_OP'(10), W_OP'(3), 1'b0, 1'b1, 0);
    expect_pair(0);
    check("sub_sum_7", op_a + ~W_OP'(3) + W_OP'(1), W_OP'(7));
    // a=10, b=3 add with cin=1: sum 14.
    load_pair(W_OP'(10), W_OP'(3), 1'b1, 1'b0, 0);
    expect_pair(0);
`endif

    check("scoreboard_drained", W_OP'(sb.size()), W_OP'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
